// File: rtl/expr_pkg.sv
// Shared constants for the expr_eval character evaluator: FSM encodings,
// ASCII codes and operator codes.
package expr_pkg;

  localparam logic [1:0] S_START = 2'd0;
  localparam logic [1:0] S_NUM   = 2'd1;
  localparam logic [1:0] S_OP    = 2'd2;
  localparam logic [1:0] S_ERR   = 2'd3;

  localparam logic [7:0] CH_PLUS  = 8'h2B;
  localparam logic [7:0] CH_MINUS = 8'h2D;
  localparam logic [7:0] CH_MUL   = 8'h2A;
  localparam logic [7:0] CH_SPACE = 8'h20;
  localparam logic [7:0] CH_0     = 8'h30;
  localparam logic [7:0] CH_9     = 8'h39;

  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_MUL = 2'd2;

endpackage

// File: rtl/expr_eval_if.sv
// Character-in / result-out bundle for expr_eval; master drives characters,
// slave (the evaluator) returns the flags and value.
interface expr_eval_if #(parameter int unsigned W = 16);
  logic [7:0]   in;
  logic         in_valid;
  logic         ok;
  logic [W-1:0] result;
  logic         err;

  modport master (output in, in_valid, input ok, result, err);
  modport slave  (input in, in_valid, output ok, result, err);
endinterface

// File: rtl/expr_char_class.sv
// Combinational ASCII classifier: digit / operator / space decoding.
module expr_char_class
  import expr_pkg::*;
(
  input  logic [7:0] in,
  output logic       is_digit,
  output logic       is_op,
  output logic [1:0] op,
  output logic [3:0] digit,
  output logic       is_space
);

  always_comb begin
    is_digit = (in >= CH_0) && (in <= CH_9);
    digit    = is_digit ? in[3:0] : 4'd0;
    is_space = (in == CH_SPACE);
    is_op    = 1'b0;
    op       = OP_ADD;
    case (in)
      CH_PLUS:  is_op = 1'b1;
      CH_MINUS: begin is_op = 1'b1; op = OP_SUB; end
      CH_MUL:   begin is_op = 1'b1; op = OP_MUL; end
      default:  ;
    endcase
  end

endmodule

// File: rtl/expr_eval.sv
// Streaming recogniser/evaluator for "operand (op operand)*" with '*' binding
// tighter than '+'/'-'. Define EXPR_SPACE_SKIP_EN to make ' ' a no-op.
module expr_eval
  import expr_pkg::*;
#(
  parameter int unsigned W          = 16,
  parameter int unsigned MAX_DIGITS = 3
) (
  input  logic        clk,
  input  logic        clr,
  expr_eval_if.slave  bus
);

  localparam int unsigned   DW       = $clog2(MAX_DIGITS + 1);
  localparam logic [DW-1:0] DCNT_MAX = DW'(MAX_DIGITS);
  localparam logic [W-1:0]  ONE      = W'(1);
`ifdef EXPR_SPACE_SKIP_EN
  localparam bit SPACE_SKIP = 1'b1;
`else
  localparam bit SPACE_SKIP = 1'b0;
`endif

  logic [1:0]    state_q, state_d;
  logic [W-1:0]  acc_q, acc_d, term_q, term_d, num_q, num_d;
  logic [DW-1:0] dcnt_q, dcnt_d;
  logic          ok_q, ok_d, err_q, err_d;
  logic [W-1:0]  result_q, result_d;

  logic          is_digit_c, is_op_c, is_space_c, accept_c;
  logic [1:0]    op_c;
  logic [3:0]    digit_c;
  logic [W-1:0]  num_ten_c;

  expr_char_class u_class (
    .in       (bus.in),
    .is_digit (is_digit_c),
    .is_op    (is_op_c),
    .op       (op_c),
    .digit    (digit_c),
    .is_space (is_space_c)
  );

  // A skipped space behaves exactly like an idle cycle.
  assign accept_c  = bus.in_valid && !(SPACE_SKIP && is_space_c);
  assign num_ten_c = (num_q << 3) + (num_q << 1);

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q  <= S_START;
      acc_q    <= '0;
      term_q   <= ONE;
      num_q    <= '0;
      dcnt_q   <= '0;
      ok_q     <= 1'b0;
      err_q    <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      term_q   <= term_d;
      num_q    <= num_d;
      dcnt_q   <= dcnt_d;
      ok_q     <= ok_d;
      err_q    <= err_d;
      result_q <= result_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    term_d   = term_q;
    num_d    = num_q;
    dcnt_d   = dcnt_q;
    ok_d     = ok_q;
    err_d    = err_q;
    result_d = result_q;
    if (accept_c) begin
      case (state_q)
        S_START, S_OP: begin
          if (is_digit_c) begin
            num_d   = W'(digit_c);
            dcnt_d  = DW'(1);
            state_d = S_NUM;
          end else begin
            state_d = S_ERR;
          end
        end
        S_NUM: begin
          if (is_digit_c) begin
            if (dcnt_q == DCNT_MAX) begin
              state_d = S_ERR;
            end else begin
              num_d  = num_ten_c + W'(digit_c);
              dcnt_d = dcnt_q + DW'(1);
            end
          end else if (is_op_c) begin
            // '*' folds into the pending term; '+'/'-' commit it to acc.
            if (op_c == OP_MUL) begin
              term_d = term_q * num_q;
            end else begin
              acc_d  = acc_q + term_q * num_q;
              term_d = (op_c == OP_SUB) ? '1 : ONE;
            end
            num_d   = '0;
            state_d = S_OP;
          end else begin
            state_d = S_ERR;
          end
        end
        default: state_d = S_ERR;
      endcase
      ok_d  = (state_d == S_NUM);
      err_d = (state_d == S_ERR);
      if (state_d == S_NUM) result_d = acc_d + term_d * num_d;
    end
  end

  assign bus.ok     = ok_q;
  assign bus.err    = err_q;
  assign bus.result = result_q;

endmodule

// File: tb/tb_expr_eval.sv
// Scoreboard bench for expr_eval: a W=16 and a W=8 instance, expected
// flags/value pushed per driven character and popped one edge later.
module tb_expr_eval;

  typedef struct {
    logic        ok;
    logic        err;
    logic [31:0] res;
  } exp_t;

`ifdef EXPR_SPACE_SKIP_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  logic clk;
  logic clr;

  expr_eval_if #(.W(16)) bus16 ();
  expr_eval_if #(.W(8))  bus8 ();

  expr_eval #(.W(16), .MAX_DIGITS(3)) dut16 (.clk(clk), .clr(clr), .bus(bus16));
  expr_eval #(.W(8),  .MAX_DIGITS(3)) dut8  (.clk(clk), .clr(clr), .bus(bus8));

  int   n_checks = 0;
  int   n_errors = 0;
  exp_t sb_q[$];

  // reference model state
  int              m_st;
  longint unsigned m_acc, m_term, m_num, m_res;
  int              m_dcnt;
  bit              m_ok, m_err;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_st = 0; m_acc = 0; m_term = 1; m_num = 0; m_dcnt = 0;
    m_ok = 0; m_err = 0; m_res = 0;
  endtask

  // States: 0 start, 1 in number, 2 after operator, 3 error.
  task automatic model_step(input byte ch, input bit w8);
    longint unsigned mask = w8 ? 64'hFF : 64'hFFFF;
    bit is_d = (ch >= "0") && (ch <= "9");
    longint unsigned d = is_d ? longint'(ch - "0") : 0;
    if (SKIP && ch == " ") return;
    case (m_st)
      0, 2: if (is_d) begin m_num = d; m_dcnt = 1; m_st = 1; end else m_st = 3;
      1: begin
        if (is_d) begin
          if (m_dcnt == 3) m_st = 3;
          else begin m_num = (m_num * 10 + d) & mask; m_dcnt++; end
        end else if (ch == "+" || ch == "-") begin
          m_acc = (m_acc + m_term * m_num) & mask;
          m_term = (ch == "-") ? mask : 1;
          m_num = 0; m_st = 2;
        end else if (ch == "*") begin
          m_term = (m_term * m_num) & mask;
          m_num = 0; m_st = 2;
        end else m_st = 3;
      end
      default: m_st = 3;
    endcase
    m_ok  = (m_st == 1);
    m_err = (m_st == 3);
    if (m_ok) m_res = (m_acc + m_term * m_num) & mask;
  endtask

  task automatic push_exp();
    exp_t e;
    e.ok = m_ok; e.err = m_err; e.res = 32'(m_res);
    sb_q.push_back(e);
  endtask

  task automatic check_pop(input string tag, input bit w8);
    exp_t e;
    if (sb_q.size() == 0) begin
      n_checks++; n_errors++;
      $display("FAIL %s: scoreboard empty got 1 expected 0", tag);
      return;
    end
    e = sb_q.pop_front();
    if (w8) begin
      chk({tag, " ok"},     32'(bus8.ok),     32'(e.ok));
      chk({tag, " err"},    32'(bus8.err),    32'(e.err));
      chk({tag, " result"}, 32'(bus8.result), e.res);
    end else begin
      chk({tag, " ok"},     32'(bus16.ok),     32'(e.ok));
      chk({tag, " err"},    32'(bus16.err),    32'(e.err));
      chk({tag, " result"}, 32'(bus16.result), e.res);
    end
  endtask

  task automatic step(input byte ch, input bit w8, input string tag);
    model_step(ch, w8);
    push_exp();
    if (w8) begin bus8.in = ch; bus8.in_valid = 1'b1; end
    else    begin bus16.in = ch; bus16.in_valid = 1'b1; end
    @(posedge clk); #1;
    bus8.in_valid = 1'b0; bus16.in_valid = 1'b0;
    check_pop(tag, w8);
  endtask

  task automatic idle(input bit w8, input string tag);
    push_exp();
    if (w8) bus8.in = "9"; else bus16.in = "9";
    @(posedge clk); #1;
    check_pop(tag, w8);
  endtask

  task automatic send(input string s, input bit w8);
    for (int i = 0; i < s.len(); i++) step(s[i], w8, $sformatf("%s[%0d]", s, i));
  endtask

  // Async clear between edges; outputs must drop before the next edge.
  task automatic pulse_clr(input string tag);
    #2 clr = 1'b1;
    #1;
    chk({tag, " clr ok"},     32'(bus16.ok),     32'd0);
    chk({tag, " clr err"},    32'(bus16.err),    32'd0);
    chk({tag, " clr result"}, 32'(bus16.result), 32'd0);
    #1 clr = 1'b0;
    model_reset();
  endtask

  initial begin
    clr = 1'b1;
    bus16.in = 8'h00; bus16.in_valid = 1'b0;
    bus8.in  = 8'h00; bus8.in_valid  = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset ok",     32'(bus16.ok),     32'd0);
    chk("reset err",    32'(bus16.err),    32'd0);
    chk("reset result", 32'(bus16.result), 32'd0);
    clr = 1'b0;

    send("1+1*2", 1'b0);
    chk("1+1*2 final", 32'(bus16.result), 32'd3);
    pulse_clr("a");

    send("12*3-40", 1'b0);
    chk("12*3-40 final", 32'(bus16.result), 32'h0000FFFC);
    pulse_clr("b");

    send("2*", 1'b0);
    pulse_clr("mid");
    send("7", 1'b0);
    chk("7 after clr", 32'(bus16.result), 32'd7);
    pulse_clr("c");

    send("+3", 1'b0);
    chk("+3 err", 32'(bus16.err), 32'd1);
    pulse_clr("d");
    send("1**", 1'b0);   pulse_clr("e");
    send("1234", 1'b0);  pulse_clr("f");
    send("5a", 1'b0);    pulse_clr("g");
    send("007", 1'b0);
    chk("007 result", 32'(bus16.result), 32'd7);
    pulse_clr("h");
    send("999*999", 1'b0);
    chk("999*999 wrap", 32'(bus16.result), 32'd14961);
    pulse_clr("i");
    send("0-1+2*3*4", 1'b0);
    pulse_clr("j");

    // A character presented while clr is high is ignored.
    clr = 1'b1;
    bus16.in = "5"; bus16.in_valid = 1'b1;
    @(posedge clk); #1;
    chk("char during clr ok",     32'(bus16.ok),     32'd0);
    chk("char during clr result", 32'(bus16.result), 32'd0);
    bus16.in_valid = 1'b0;
    clr = 1'b0;
    model_reset();

    send("3 * 4", 1'b0);
    if (SKIP) begin
      chk("space skip result", 32'(bus16.result), 32'd12);
      chk("space skip ok",     32'(bus16.ok),     32'd1);
    end else begin
      chk("space illegal err", 32'(bus16.err), 32'd1);
    end
    pulse_clr("k");
    send("1 2", 1'b0);
    pulse_clr("l");

    // W=8 path with idle gaps between characters.
    begin
      string s = "255+1";
      for (int i = 0; i < s.len(); i++) begin
        step(s[i], 1'b1, $sformatf("w8 %s[%0d]", s, i));
        idle(1'b1, "w8 gap0");
        idle(1'b1, "w8 gap1");
      end
    end
    chk("w8 final result", 32'(bus8.result), 32'd0);
    chk("w8 final ok",     32'(bus8.ok),     32'd1);

    if (sb_q.size() != 0) begin
      n_checks++; n_errors++;
      $display("FAIL scoreboard leftover: got %0d expected 0", sb_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
